// File: rtl/snap_sequencer_if.sv
// Handshake/bus bundle for snap_sequencer: one input vector stream in, one snapped result stream out.
interface snap_sequencer_if #(
  parameter int unsigned N_DIM = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [16*N_DIM-1:0]  coord_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*N_DIM-1:0]   coord_out;
  logic [N_DIM-1:0]     sat_flags;
  logic                 stable;
  logic                 busy;

  modport slave (
    input  in_valid, coord_in, out_ready,
    output in_ready, out_valid, coord_out, sat_flags, stable, busy
  );

  modport master (
    output in_valid, coord_in, out_ready,
    input  in_ready, out_valid, coord_out, sat_flags, stable, busy
  );
endinterface

// File: rtl/snap_sequencer.sv
// Snaps a vector of signed 8.8 lanes to signed 8-bit integers, one lane per cycle through a
// single rounding datapath, and flags whether the result repeats the previously delivered one.
module snap_sequencer #(
  parameter int unsigned N_DIM = 4
) (
  input  logic               clk,
  input  logic               rst,
  snap_sequencer_if.slave    bus
);
  localparam int unsigned IN_W  = 16 * N_DIM;
  localparam int unsigned OUT_W = 8 * N_DIM;
  localparam int unsigned IDX_W = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIM - 1);

  typedef enum logic [1:0] {IDLE, SNAP, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IN_W-1:0]    r_coord;
  logic [IDX_W-1:0]   r_idx;
  logic [OUT_W-1:0]   r_coord_out;
  logic [OUT_W-1:0]   r_prev_result;
  logic [N_DIM-1:0]   r_sat;
  logic               r_out_valid;
  logic               r_stable;
  logic               r_prev_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic [15:0]        w_lane;
  logic               w_sat;
  logic [7:0]         w_rnd;
  logic [OUT_W-1:0]   w_coord_upd;
  logic [N_DIM-1:0]   w_sat_upd;
  logic               w_accept;
  logic               w_last;
  logic               w_release;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      IDLE: if (bus.in_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = SNAP;
      end
      SNAP: if (r_idx == LAST_IDX) begin
        w_last      = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: if (bus.out_ready) begin
        w_release   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the lane currently being snapped
  always_comb begin
    w_lane = '0;
    for (int unsigned k = 0; k < N_DIM; k++) begin
      if (r_idx == IDX_W'(k)) w_lane = r_coord[16*k +: 16];
    end
  end

  // Shared rounding datapath: clamp above 0x7F00, else round-half-down via +0x7F then drop fraction
  always_comb begin
    w_sat = ($signed(w_lane) > $signed(16'h7F00));
    w_rnd = w_sat ? 8'd127 : 8'((17'({w_lane[15], w_lane}) + 17'h0007F) >> 8);
  end

  // Result vector with the current lane replaced
  always_comb begin
    w_coord_upd = r_coord_out;
    w_sat_upd   = r_sat;
    for (int unsigned k = 0; k < N_DIM; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_coord_upd[8*k +: 8] = w_rnd;
        w_sat_upd[k]          = w_sat;
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coord       <= '0;
      r_idx         <= '0;
      r_coord_out   <= '0;
      r_sat         <= '0;
      r_out_valid   <= 1'b0;
      r_stable      <= 1'b0;
      r_prev_valid  <= 1'b0;
      r_prev_result <= '0;
      r_in_ready    <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == IDLE);
      r_busy     <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_coord <= bus.coord_in;
        r_idx   <= '0;
      end
      if (r_state == SNAP) begin
        r_coord_out <= w_coord_upd;
        r_sat       <= w_sat_upd;
        r_idx       <= r_idx + IDX_W'(1);
      end
      if (w_last) begin
        r_out_valid <= 1'b1;
        r_stable    <= r_prev_valid && (w_coord_upd == r_prev_result);
      end
      if (w_release) begin
        r_prev_result <= r_coord_out;
        r_prev_valid  <= 1'b1;
        r_out_valid   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.coord_out = r_coord_out;
  assign bus.sat_flags = r_sat;
  assign bus.stable    = r_stable;
endmodule

// File: tb/tb_snap_sequencer.sv
// Directed bench for snap_sequencer: a vector-level reference model checked every cycle,
// plus literal expectations for the rounding, saturation, backpressure, stability and reset cases.
module tb_snap_sequencer;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snap_sequencer_if #(.N_DIM(N)) bus ();
  snap_sequencer #(.N_DIM(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arithmetic snap of one 8.8 lane: {sat, value}
  function automatic logic [8:0] snap9(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v > 32512) return {1'b1, 8'd127};
    return {1'b0, 8'((v + 127) >>> 8)};
  endfunction

  // Reference model: whole result computed at accept, revealed one lane per cycle
  logic [8*N-1:0] m_out, m_full, m_prev;
  logic [N-1:0]   m_sat, m_full_sat;
  int             m_k;
  bit             m_snap, m_done, m_prev_valid, m_stable;

  always @(posedge clk) begin
    if (rst) begin
      m_out <= '0; m_sat <= '0; m_prev <= '0; m_prev_valid <= 1'b0;
      m_snap <= 1'b0; m_done <= 1'b0; m_stable <= 1'b0; m_k <= 0;
    end else if (!m_snap && !m_done) begin
      if (bus.in_valid) begin
        for (int k = 0; k < int'(N); k++)
          {m_full_sat[k], m_full[8*k +: 8]} <= snap9(bus.coord_in[16*k +: 16]);
        m_k    <= 0;
        m_snap <= 1'b1;
      end
    end else if (m_snap) begin
      m_out[8*m_k +: 8] <= m_full[8*m_k +: 8];
      m_sat[m_k]        <= m_full_sat[m_k];
      m_k               <= m_k + 1;
      if (m_k == int'(N) - 1) begin
        m_snap   <= 1'b0;
        m_done   <= 1'b1;
        m_stable <= m_prev_valid && (m_full == m_prev);
      end
    end else if (bus.out_ready) begin
      m_prev       <= m_out;
      m_prev_valid <= 1'b1;
      m_done       <= 1'b0;
    end
  end

  // Cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_in_ready",  64'(bus.in_ready),  64'(!m_snap && !m_done));
      check("cyc_busy",      64'(bus.busy),      64'(m_snap || m_done));
      check("cyc_out_valid", 64'(bus.out_valid), 64'(m_done));
      check("cyc_coord_out", 64'(bus.coord_out), 64'(m_out));
      check("cyc_sat_flags", 64'(bus.sat_flags), 64'(m_sat));
      check("cyc_stable",    64'(bus.stable),    64'(m_stable));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    check({nm, "_in_ready"}, 64'(bus.in_ready), 64'(1));
  endtask

  // Send one vector, check latency and result, hold for 'hold' cycles with a stray in_valid, release
  task automatic txn(input string nm, input logic [63:0] v, input int hold,
                     input logic [31:0] ec, input logic [3:0] es, input logic est);
    int n;
    wait_ready(nm);
    bus.coord_in = v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.coord_in = ~v;
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check({nm, "_latency"}, 64'(n), 64'(N));
    check({nm, "_coord"},   64'(bus.coord_out), 64'(ec));
    check({nm, "_sat"},     64'(bus.sat_flags), 64'(es));
    check({nm, "_stable"},  64'(bus.stable),    64'(est));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      tick();
      check({nm, "_hold_coord"}, 64'(bus.coord_out), 64'(ec));
      check({nm, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
      check({nm, "_hold_ready"}, 64'(bus.in_ready),  64'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({nm, "_drop_valid"}, 64'(bus.out_valid), 64'(0));
    check({nm, "_idle_ready"}, 64'(bus.in_ready),  64'(1));
  endtask

  localparam logic [63:0] V_CORNER = {16'hFF81, 16'hFF80, 16'h0181, 16'h0180};
  localparam logic [63:0] V_SAT    = {16'h8000, 16'h7FFF, 16'h7F01, 16'h7F00};
  localparam logic [63:0] V_BP     = {16'h1234, 16'h00C0, 16'hFFFF, 16'h4000};
  localparam logic [63:0] V_B      = {16'h0300, 16'h0280, 16'h0100, 16'hFE00};
  localparam logic [63:0] V_B3     = {16'h0400, 16'h0280, 16'h0100, 16'hFE00};

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.coord_in  = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) tick();
    check("rst_busy",      64'(bus.busy),      64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_coord",     64'(bus.coord_out), 64'(0));
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    txn("corner", V_CORNER, 0, 32'h00FF0201, 4'b0000, 1'b0);
    txn("sat",    V_SAT,    0, 32'h807F7F7F, 4'b0110, 1'b0);

    // out_ready raised before the result exists: one-cycle out_valid pulse
    wait_ready("early");
    bus.out_ready = 1'b1;
    bus.coord_in  = V_SAT;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check("early_latency", 64'(n), 64'(N));
    check("early_stable",  64'(bus.stable), 64'(1));
    tick();
    bus.out_ready = 1'b0;
    check("early_drop_valid", 64'(bus.out_valid), 64'(0));

    txn("bp",      V_BP, 10, 32'h12010040, 4'b0000, 1'b0);
    txn("stab1",   V_B,  0,  32'h030201FE, 4'b0000, 1'b0);
    txn("stab2",   V_B,  0,  32'h030201FE, 4'b0000, 1'b1);
    txn("stab_l3", V_B3, 0,  32'h040201FE, 4'b0000, 1'b0);

    // Reset sampled on the second SNAP edge
    wait_ready("midrst");
    bus.coord_in = V_B;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy",   64'(bus.busy),      64'(0));
    check("midrst_valid",  64'(bus.out_valid), 64'(0));
    check("midrst_coord",  64'(bus.coord_out), 64'(0));
    check("midrst_sat",    64'(bus.sat_flags), 64'(0));
    check("midrst_stable", 64'(bus.stable),    64'(0));
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) n++;
    end
    check("midrst_no_pulse", 64'(n), 64'(0));
    txn("after_rst", V_B, 0, 32'h030201FE, 4'b0000, 1'b0);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/snap_sequencer.md
SNAP_SEQUENCER -- requirements
Module: snap_sequencer

Interface
REQ-001 SHALL have parameter N_DIM, default 4, giving the number of coordinate lanes per vector (legal values 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream has a coordinate vector on coord_in.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-006 SHALL have port coord_in, input, 16*N_DIM bits: signed 8.8 fixed-point lanes; lane k occupies bits [16k+15:16k].
REQ-007 SHALL have port out_valid, output, 1 bit: coord_out, sat_flags and stable are valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-009 SHALL have port coord_out, output, 8*N_DIM bits: signed 8-bit snapped lanes; lane k occupies bits [8k+7:8k].
REQ-010 SHALL have port sat_flags, output, N_DIM bits: bit k is 1 when lane k was clamped to 127.
REQ-011 SHALL have port stable, output, 1 bit: the current result equals the previously delivered result.
REQ-012 SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-013 SHALL contain exactly one rounding datapath, time-multiplexed across lanes at one lane per cycle.
REQ-014 SHALL compute each lane from input x as follows: if x > 0x7F00 (signed), the result is 127 and the sat bit is 1; otherwise the result is bits [15:8] of x + 0x007F, computed at 17-bit width, and the sat bit is 0.
REQ-015 SHALL implement the FSM states IDLE, SNAP and DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE, and SHALL ignore in_valid in SNAP and DONE.
REQ-017 SHALL, on an IDLE edge with in_valid=1, register all of coord_in, clear lane index idx to 0, and enter SNAP.
REQ-018 SHALL, in SNAP, round lane idx on each edge, write it to coord_out lane idx and sat_flags[idx], and increment idx.
REQ-019 SHALL snap lanes in ascending order 0..N_DIM-1.
REQ-020 SHALL, on the edge that writes lane N_DIM-1, enter DONE.
REQ-021 SHALL therefore assert out_valid exactly N_DIM cycles after the accept edge (4 cycles at the default).
REQ-022 SHALL, on that same edge, set stable=1 if prev_valid=1 and every new lane equals the corresponding lane of prev_result; otherwise stable=0.
REQ-023 SHALL hold out_valid, coord_out, sat_flags and stable constant in DONE until out_ready=1.
REQ-024 SHALL, on a DONE edge with out_ready=1, copy coord_out to prev_result, set prev_valid=1, deassert out_valid, and return to IDLE.
REQ-025 SHALL NOT accept a new vector on the same edge it returns to IDLE; the minimum spacing between accepts is N_DIM+2 cycles.
REQ-026 SHALL allow an out_ready asserted before out_valid, with no effect until DONE.
REQ-027 SHALL keep coord_out and sat_flags holding their last values in IDLE; only out_valid qualifies them.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, force: state IDLE, idx 0, out_valid 0, coord_out all 0, sat_flags 0, stable 0, busy 0, prev_valid 0, prev_result all 0.
REQ-029 SHALL let rst override everything in any state; reset mid-SNAP or mid-DONE discards the vector in flight and produces no out_valid pulse.
REQ-030 SHALL drive in_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-031 SHALL be verified with rounding corners: lanes {0x0180, 0x0181, 0xFF80, 0xFF81} -> coord_out lanes {1, 2, -1, 0}, sat_flags 0000, out_valid 4 cycles after accept.
REQ-032 SHALL be verified with saturation: lanes {0x7F00, 0x7F01, 0x7FFF, 0x8000} -> {127, 127, 127, -128}, sat_flags 0110.
REQ-033 SHALL be verified with backpressure: out_ready held 0 for 10 cycles -> outputs constant, in_ready 0, and a new in_valid is ignored; out_ready=1 -> out_valid drops next cycle, then in_ready=1.
REQ-034 SHALL be verified with stability: the same vector sent twice -> stable 0 on the first result and 1 on the second; then a vector differing only in lane 3 -> stable 0.
REQ-035 SHALL be verified with reset mid-operation: rst asserted on the 2nd SNAP cycle -> busy 0 and all outputs 0 next cycle, no out_valid; the next identical vector yields stable 0.
